// File: rtl/xbus_pkg.sv
// xbus_pkg: shared X-bus widths, feeder FSM states and tag/value field helpers
package xbus_pkg;

    localparam int XB_ID_LEN    = 5;
    localparam int XB_VALUE_LEN = 32;

    typedef enum logic [1:0] {IDLE, DRAIN, SCAN, DONE} xbus_state_e;

    function automatic logic [XB_ID_LEN-1:0] tag_of(input logic [XB_VALUE_LEN+XB_ID_LEN-1:0] tv);
        return tv[XB_VALUE_LEN+XB_ID_LEN-1 -: XB_ID_LEN];
    endfunction

    function automatic logic [XB_VALUE_LEN-1:0] value_of(input logic [XB_VALUE_LEN+XB_ID_LEN-1:0] tv);
        return tv[XB_VALUE_LEN-1:0];
    endfunction

endpackage

// File: rtl/xbus_feeder_fifo.sv
// xbus_feeder_fifo: synchronous FIFO with MSB-wrap pointers and a combinational head read
module xbus_feeder_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Write the tail slot and advance whichever pointers moved
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointers clear on reset; storage is masked by empty so it needs none
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/xbus_feeder.sv
// xbus_feeder: buffers tagged words toward the X-bus and scans multicast IDs into the PE chain.
// Optional saturating perf counters are built when XBUS_FEEDER_PERF_CNT_EN is defined.
module xbus_feeder
    import xbus_pkg::*;
#(
    parameter int PE_NUMS   = 14,
    parameter int ID_LEN    = XB_ID_LEN,
    parameter int VALUE_LEN = XB_VALUE_LEN,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [VALUE_LEN+ID_LEN-1:0]  in_tag_value,
    output logic                         xbus_enable,
    input  logic                         xbus_ready,
    output logic [VALUE_LEN+ID_LEN-1:0]  xbus_tag_value,
    input  logic                         cfg_start,
    input  logic [PE_NUMS*ID_LEN-1:0]    cfg_id_table,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         set_id,
    output logic [ID_LEN-1:0]            id_scan_out
`ifdef XBUS_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_xfer_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    localparam int KW = PE_NUMS > 1 ? $clog2(PE_NUMS) : 1;

    xbus_state_e                  state_q, state_d;
    logic [KW-1:0]                k_q, k_d;
    logic [PE_NUMS*ID_LEN-1:0]    table_q, table_d;
    logic                         set_id_q, set_id_d, cfg_busy_q, cfg_busy_d, cfg_done_q, cfg_done_d;
    logic [ID_LEN-1:0]            id_scan_out_q, id_scan_out_d;
    logic                         full, empty, push, pop;
    logic [$clog2(DEPTH):0]       level;

    assign push        = in_valid && in_ready;
    assign pop         = xbus_enable && xbus_ready;
    assign set_id      = set_id_q;
    assign id_scan_out = id_scan_out_q;
    assign cfg_busy    = cfg_busy_q;
    assign cfg_done    = cfg_done_q;

    xbus_feeder_fifo #(.W(VALUE_LEN+ID_LEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_tag_value),
        .dout  (xbus_tag_value),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // State and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            table_q       <= '0;
            set_id_q      <= 1'b0;
            id_scan_out_q <= '0;
            cfg_busy_q    <= 1'b0;
            cfg_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            table_q       <= table_d;
            set_id_q      <= set_id_d;
            id_scan_out_q <= id_scan_out_d;
            cfg_busy_q    <= cfg_busy_d;
            cfg_done_q    <= cfg_done_d;
        end
    end

    // Next state; a word accepted alongside cfg_start is drained before scanning
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = (empty && !push) ? SCAN : DRAIN;
            DRAIN:   if (empty || (level == 1 && pop)) state_d = SCAN;
            SCAN:    if (k_q == KW'(PE_NUMS-1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode and next values of the registered scan controls
    always_comb begin
        in_ready      = rst && state_q == IDLE && !full;
        xbus_enable   = (state_q == IDLE || state_q == DRAIN) && !empty;
        table_d       = (state_q == IDLE && cfg_start) ? cfg_id_table : table_q;
        k_d           = state_q == SCAN ? k_q + KW'(1) : '0;
        set_id_d      = state_d == SCAN;
        id_scan_out_d = set_id_d ? table_d[(PE_NUMS-1-int'(k_d))*ID_LEN +: ID_LEN] : '0;
        cfg_busy_d    = state_d == DRAIN || state_d == SCAN;
        cfg_done_d    = state_d == DONE;
    end

`ifdef XBUS_FEEDER_PERF_CNT_EN
    logic [31:0] perf_xfer_cnt_q, perf_xfer_cnt_d, perf_stall_cnt_q, perf_stall_cnt_d;

    assign perf_xfer_cnt  = perf_xfer_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;

    // Saturating transfer and stall counts
    always_comb begin
        perf_xfer_cnt_d  = perf_xfer_cnt_q + 32'(pop && !(&perf_xfer_cnt_q));
        perf_stall_cnt_d = perf_stall_cnt_q + 32'(xbus_enable && !xbus_ready && !(&perf_stall_cnt_q));
    end

    // Counters clear on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_xfer_cnt_q  <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_xfer_cnt_q  <= perf_xfer_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_xbus_feeder.sv
// tb_xbus_feeder: directed self-checking bench for xbus_feeder
module tb_xbus_feeder;

    localparam int PE_NUMS = 14;
    localparam int ID_LEN = 5;
    localparam int VALUE_LEN = 32;
    localparam int TVW = VALUE_LEN + ID_LEN;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [TVW-1:0]            in_tag_value = '0;
    logic                      xbus_enable;
    logic                      xbus_ready = 1'b0;
    logic [TVW-1:0]            xbus_tag_value;
    logic                      cfg_start = 1'b0;
    logic [PE_NUMS*ID_LEN-1:0] cfg_id_table = '0;
    logic                      cfg_busy;
    logic                      cfg_done;
    logic                      set_id;
    logic [ID_LEN-1:0]         id_scan_out;

    int tests = 0;
    int fails = 0;

    xbus_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_tag_value   (in_tag_value),
        .xbus_enable    (xbus_enable),
        .xbus_ready     (xbus_ready),
        .xbus_tag_value (xbus_tag_value),
        .cfg_start      (cfg_start),
        .cfg_id_table   (cfg_id_table),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .set_id         (set_id),
        .id_scan_out    (id_scan_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TVW-1:0] word(input int n);
        return {5'(n % 32), 32'hC000_0000 + 32'(n)};
    endfunction

    function automatic logic [PE_NUMS*ID_LEN-1:0] make_table(input int base);
        logic [PE_NUMS*ID_LEN-1:0] t;
        t = '0;
        for (int i = 0; i < PE_NUMS; i++) t[i*ID_LEN +: ID_LEN] = ID_LEN'(i + base);
        return t;
    endfunction

    initial begin
        // reset
        step();
        step();
        chk("rst_enable", 64'(xbus_enable), 64'd0);
        chk("rst_set_id", 64'(set_id), 64'd0);
        chk("rst_id_out", 64'(id_scan_out), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // single word, no bypass
        xbus_ready = 1'b1;
        in_valid = 1'b1;
        in_tag_value = {5'd3, 32'h0000_00AA};
        chk("single_enable_pre", 64'(xbus_enable), 64'd0);
        step();
        in_valid = 1'b0;
        chk("single_enable", 64'(xbus_enable), 64'd1);
        chk("single_word", 64'(xbus_tag_value), 64'h03_0000_00AA);
        step();
        chk("single_empty", 64'(xbus_enable), 64'd0);

        // fill to full with bus stalled
        xbus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_tag_value = word(i);
            chk($sformatf("fill_ready_%0d", i), 64'(in_ready), 64'd1);
            step();
        end
        in_tag_value = word(4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(xbus_tag_value), 64'(word(0)));
        step();
        in_valid = 1'b0;
        chk("stall_head", 64'(xbus_tag_value), 64'(word(0)));
        chk("stall_enable", 64'(xbus_enable), 64'd1);
        xbus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_head_%0d", i), 64'(xbus_tag_value), 64'(word(i)));
            step();
        end
        chk("drain_empty", 64'(xbus_enable), 64'd0);

        // streaming at occupancy 2
        xbus_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_tag_value = word(100 + i);
            step();
        end
        xbus_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_tag_value = word(102 + n);
            chk($sformatf("stream_ready_%0d", n), 64'(in_ready), 64'd1);
            chk($sformatf("stream_head_%0d", n), 64'(xbus_tag_value), 64'(word(100 + n)));
            step();
        end
        in_valid = 1'b0;
        chk("stream_tail0", 64'(xbus_tag_value), 64'(word(120)));
        step();
        chk("stream_tail1", 64'(xbus_tag_value), 64'(word(121)));
        step();
        chk("stream_empty", 64'(xbus_enable), 64'd0);

        // ID scan with empty FIFO
        cfg_id_table = make_table(0);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_id_table = '0;
        chk("scan_busy", 64'(cfg_busy), 64'd1);
        chk("scan_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < PE_NUMS; k++) begin
            chk($sformatf("scan_set_id_%0d", k), 64'(set_id), 64'd1);
            chk($sformatf("scan_id_%0d", k), 64'(id_scan_out), 64'(PE_NUMS - 1 - k));
            step();
        end
        chk("scan_done", 64'(cfg_done), 64'd1);
        chk("scan_done_set_id", 64'(set_id), 64'd0);
        chk("scan_done_busy", 64'(cfg_busy), 64'd0);
        step();
        chk("scan_done_pulse", 64'(cfg_done), 64'd0);
        chk("scan_idle_ready", 64'(in_ready), 64'd1);

        // drain three queued words before scanning
        xbus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_tag_value = word(200 + i);
            step();
        end
        in_valid = 1'b0;
        cfg_id_table = make_table(16);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        in_valid = 1'b1;
        in_tag_value = word(250);
        chk("drain_busy", 64'(cfg_busy), 64'd1);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        chk("drain_set_id", 64'(set_id), 64'd0);
        xbus_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_word_%0d", i), 64'(xbus_tag_value), 64'(word(200 + i)));
            chk($sformatf("drain_enable_%0d", i), 64'(xbus_enable), 64'd1);
            chk($sformatf("drain_blocked_%0d", i), 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < PE_NUMS; k++) begin
            cfg_start = (k == 2);
            cfg_id_table = '0;
            chk($sformatf("scan2_set_id_%0d", k), 64'(set_id), 64'd1);
            chk($sformatf("scan2_id_%0d", k), 64'(id_scan_out), 64'(16 + PE_NUMS - 1 - k));
            chk($sformatf("scan2_enable_%0d", k), 64'(xbus_enable), 64'd0);
            step();
        end
        cfg_start = 1'b0;
        chk("scan2_done", 64'(cfg_done), 64'd1);
        step();
        chk("scan2_idle_done", 64'(cfg_done), 64'd0);
        chk("scan2_idle_busy", 64'(cfg_busy), 64'd0);

        // reset in the middle of a scan
        cfg_id_table = make_table(0);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("mid_scan_id", 64'(id_scan_out), 64'd7);
        rst = 1'b0;
        step();
        chk("mid_rst_set_id", 64'(set_id), 64'd0);
        chk("mid_rst_id", 64'(id_scan_out), 64'd0);
        chk("mid_rst_busy", 64'(cfg_busy), 64'd0);
        chk("mid_rst_enable", 64'(xbus_enable), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_enable", 64'(xbus_enable), 64'd0);
        in_valid = 1'b1;
        in_tag_value = word(300);
        step();
        in_valid = 1'b0;
        chk("mid_rel_word", 64'(xbus_tag_value), 64'(word(300)));
        step();
        chk("mid_rel_empty", 64'(xbus_enable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
